// File: rtl/maze_pkg.sv
// Shared maze definitions: location bus geometry, path reader FSM states and
// the row/col field extractors used by the stack, the solver and the path reader.
package maze_pkg;

   localparam int LOC_W = 8;
   localparam int ROW_W = 4;
   localparam int COL_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DONE   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_LOAD   = 3'd3,
      ST_EMIT   = 3'd4,
      ST_FIN    = 3'd5
   } rd_state_t;

   function automatic logic [ROW_W-1:0] loc_row(input logic [LOC_W-1:0] loc);
      return loc[LOC_W-1 -: ROW_W];
   endfunction

   function automatic logic [COL_W-1:0] loc_col(input logic [LOC_W-1:0] loc);
      return loc[COL_W-1:0];
   endfunction

endpackage

// File: rtl/path_reader.sv
// Reader side of the location stack: pulses done once, then pops each stored
// location and presents it as row/col on a valid/ready port, counting the path.
module path_reader
   import maze_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LOC_W-1:0] stkLoc,
   input  logic             stkEmp,
   output logic             stkDone,
   output logic             stkPop,
   output logic [ROW_W-1:0] outRow,
   output logic [COL_W-1:0] outCol,
   output logic             outValid,
   input  logic             outReady,
   output logic             busy,
   output logic             fin,
   output logic [CNT_W-1:0] pathLen
);

   localparam logic [CNT_W-1:0] LEN_MAX = '1;

   rd_state_t        state_reg;
   rd_state_t        state_next;
   logic [ROW_W-1:0] row_reg;
   logic [COL_W-1:0] col_reg;
   logic [CNT_W-1:0] len_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // SETTLE gives the stack one cycle to present the new top after done/pop.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE:   if (start) state_next = ST_DONE;
         ST_DONE:   state_next = ST_SETTLE;
         ST_SETTLE: state_next = ST_LOAD;
         ST_LOAD:   state_next = stkEmp ? ST_FIN : ST_EMIT;
         ST_EMIT:   if (outReady) state_next = ST_SETTLE;
         ST_FIN:    state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      stkDone  = (state_reg == ST_DONE);
      stkPop   = (state_reg == ST_LOAD) && !stkEmp;
      outValid = (state_reg == ST_EMIT);
      fin      = (state_reg == ST_FIN);
      busy     = (state_reg != ST_IDLE);
   end

   // Row/col are held after fin so the display keeps the final location.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_reg <= '0;
         col_reg <= '0;
         len_reg <= '0;
      end else begin
         if (state_reg == ST_IDLE && start) begin
            len_reg <= '0;
         end
         if (state_reg == ST_LOAD && !stkEmp) begin
            row_reg <= loc_row(stkLoc);
            col_reg <= loc_col(stkLoc);
         end
         if (state_reg == ST_EMIT && outReady && len_reg != LEN_MAX) begin
            len_reg <= len_reg + 1'b1;
         end
      end
   end

   assign outRow  = row_reg;
   assign outCol  = col_reg;
   assign pathLen = len_reg;

endmodule
